// File: rtl/unsigned_multiplier_arbiter_4_port_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the 4-port multiplier arbiter.
// Widths: 4-bit operands, 8-bit full product, 2-bit requester id.
package unsigned_multiplier_arbiter_4_port_pkg;

  localparam int NUM_PORTS = 4;
  localparam int OP_W      = 4;
  localparam int RES_W     = 2 * OP_W;
  localparam int ID_W      = 2;

  // Pointer starts at the last port so port 0 wins the first arbitration.
  localparam logic [ID_W-1:0] PTR_RST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] ptr, input int k);
    return ID_W'(int'(ptr) + k);
  endfunction

endpackage

// File: rtl/unsigned_multiplier_arbiter_4_port_if.sv
// Request/result bus between requesters, the arbiter and the result consumer.
// slave = arbiter side, master = requester/consumer side.
interface unsigned_multiplier_arbiter_4_port_if;
  import unsigned_multiplier_arbiter_4_port_pkg::*;

  logic [NUM_PORTS-1:0]      Req_Valid_In;
  logic [NUM_PORTS*OP_W-1:0] Req_Data_A_In;
  logic [NUM_PORTS*OP_W-1:0] Req_Data_B_In;
  logic [NUM_PORTS-1:0]      Req_Ready_Out;
  logic                      Result_Valid_Out;
  logic [RES_W-1:0]          Result_Data_Out;
  logic [ID_W-1:0]           Result_Id_Out;
  logic                      Result_Ready_In;
  logic                      Busy_Out;

  modport slave (
    input  Req_Valid_In,
    input  Req_Data_A_In,
    input  Req_Data_B_In,
    input  Result_Ready_In,
    output Req_Ready_Out,
    output Result_Valid_Out,
    output Result_Data_Out,
    output Result_Id_Out,
    output Busy_Out
  );

  modport master (
    output Req_Valid_In,
    output Req_Data_A_In,
    output Req_Data_B_In,
    output Result_Ready_In,
    input  Req_Ready_Out,
    input  Result_Valid_Out,
    input  Result_Data_Out,
    input  Result_Id_Out,
    input  Busy_Out
  );

endinterface

// File: rtl/unsigned_multiplier_arbiter_4_port_mult.sv
// Combinational 4x4 unsigned array multiplier: shifted partial-product rows summed by ripple adders.
// Zero latency; output forced to 0 when disabled so it is never left floating.
module Unsigned_Array_Multiplier_4_Bit
  import unsigned_multiplier_arbiter_4_port_pkg::*;
(
  input  logic             mult_en,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [RES_W-1:0] product
);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] addend;
  logic [RES_W-1:0] sum_row;
  logic             carry;

  always_comb begin
    acc     = '0;
    addend  = '0;
    sum_row = '0;
    carry   = 1'b0;
    for (int i = 0; i < OP_W; i++) begin
      addend = op_b[i] ? (RES_W'(op_a) << i) : '0;
      carry  = 1'b0;
      for (int j = 0; j < RES_W; j++) begin
        sum_row[j] = acc[j] ^ addend[j] ^ carry;
        carry      = (acc[j] & addend[j]) | (carry & (acc[j] ^ addend[j]));
      end
      acc = sum_row;
    end
  end

  assign product = mult_en ? acc : '0;

endmodule

// File: rtl/unsigned_multiplier_arbiter_4_port.sv
// Round-robin arbiter feeding one 4x4 multiplier; result valid 2 cycles after request accept.
// Result held until Result_Ready_In; no request accepted while a product is in flight or unconsumed.
module unsigned_multiplier_arbiter_4_port
  import unsigned_multiplier_arbiter_4_port_pkg::*;
#(
  parameter int NUM_PORTS = unsigned_multiplier_arbiter_4_port_pkg::NUM_PORTS
) (
  input  logic                                 Clock_In,
  input  logic                                 Reset_In,
  unsigned_multiplier_arbiter_4_port_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic [RES_W-1:0]  res_dat_q, res_dat_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_vld_q, res_vld_d;
  logic              busy_q, busy_d;

  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   rr_cand;
  logic              any_req;
  logic              can_accept;
  logic              grant;
  logic [3:0]        req_rdy;
  logic [RES_W-1:0]  mult_prod;

  // Search order starts one past the last winner, ending on the last winner itself.
  always_comb begin
    any_req = 1'b0;
    win_id  = ptr_q;
    rr_cand = ptr_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_cand = rr_next(ptr_q, k);
      if (!any_req && bus.Req_Valid_In[rr_cand]) begin
        any_req = 1'b1;
        win_id  = rr_cand;
      end
    end
  end

  // Accept in IDLE, or in RESULT on the same cycle the held product is consumed.
  assign can_accept = !Reset_In &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_RESULT) && bus.Result_Ready_In));
  assign grant      = can_accept && any_req;

  always_comb begin
    req_rdy = '0;
    if (grant) begin
      req_rdy[win_id] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_id_d   = op_id_q;
    res_dat_d = res_dat_q;
    res_id_d  = res_id_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        res_dat_d = mult_prod;
        res_id_d  = op_id_q;
        state_d   = ST_RESULT;
      end
      ST_RESULT: begin
        if (bus.Result_Ready_In) begin
          state_d = grant ? ST_MULT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      ptr_d   = win_id;
      op_a_d  = bus.Req_Data_A_In[OP_W*win_id +: OP_W];
      op_b_d  = bus.Req_Data_B_In[OP_W*win_id +: OP_W];
      op_id_d = win_id;
    end

    res_vld_d = (state_d == ST_RESULT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= '0;
      res_dat_q <= '0;
      res_id_q  <= '0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_id_q   <= op_id_d;
      res_dat_q <= res_dat_d;
      res_id_q  <= res_id_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
    end
  end

  Unsigned_Array_Multiplier_4_Bit u_mult (
    .mult_en (1'b1),
    .op_a    (op_a_q),
    .op_b    (op_b_q),
    .product (mult_prod)
  );

  assign bus.Req_Ready_Out    = req_rdy;
  assign bus.Result_Valid_Out = res_vld_q;
  assign bus.Result_Data_Out  = res_dat_q;
  assign bus.Result_Id_Out    = res_id_q;
  assign bus.Busy_Out         = busy_q;

endmodule

// File: doc/unsigned_multiplier_arbiter_4_port.md
UNSIGNED_MULTIPLIER_ARBITER_4_PORT -- requirements
Module: Unsigned_Multiplier_Arbiter_4_Port

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters; only 4 is supported.
REQ-002 SHALL have port Clock_In, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port Reset_In, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Req_Valid_In, input, 4, per-port request valid.
REQ-005 SHALL have port Req_Data_A_In, input, 16, 4-bit operand A per port; port n is bits [4n+3:4n].
REQ-006 SHALL have port Req_Data_B_In, input, 16, 4-bit operand B per port, same packing as A.
REQ-007 SHALL have port Req_Ready_Out, output, 4, per-port accept; at most one bit high.
REQ-008 SHALL have port Result_Valid_Out, output, 1, result available.
REQ-009 SHALL have port Result_Data_Out, output, 8, unsigned product A*B.
REQ-010 SHALL have port Result_Id_Out, output, 2, index of the requesting port.
REQ-011 SHALL have port Result_Ready_In, input, 1, consumer accepts result.
REQ-012 SHALL have port Busy_Out, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL use a request handshake in which a transfer occurs on a cycle where Req_Valid_In[n] and Req_Ready_Out[n] are both 1; the result handshake is the same with Result_Valid_Out and Result_Ready_In.
REQ-014 SHALL implement FSM states IDLE, MULT and RESULT.
REQ-015 SHALL behave as follows in IDLE: if any Req_Valid_In bit is 1, grant exactly one port (REQ-017), assert its Req_Ready_Out combinationally, latch A, B and id into operand registers, and go to MULT; otherwise stay in IDLE.
REQ-016 SHALL behave as follows in MULT: register the multiplier product and the id into the result registers, then go to RESULT unconditionally.
REQ-017 SHALL grant by round-robin from a 2-bit pointer holding the last granted port; priority order is pointer+1, pointer+2, pointer+3, pointer (mod 4), and the pointer updates to the winner on each grant.
REQ-018 SHALL behave as follows in RESULT: hold Result_Valid_Out=1 with stable data and id until Result_Ready_In=1. On acceptance, if any request is valid, grant it in the same cycle (per REQ-015) and go to MULT; otherwise go to IDLE.
REQ-019 SHALL keep Req_Ready_Out at 0 in MULT, and in RESULT while Result_Ready_In=0.
REQ-020 SHALL have a latency of 2 cycles from request acceptance edge to Result_Valid_Out=1; peak throughput is one product per 2 cycles.
REQ-021 SHALL produce Result_Data_Out equal to the full 8-bit unsigned product (max 15*15=225), with no truncation or saturation.
REQ-022 SHALL ignore operands of non-granted ports; a requester whose Req_Valid_In drops before grant loses nothing and causes no error.
REQ-023 SHALL tie the multiplier enable high internally so that the product is never high-impedance.

Reset
REQ-024 SHALL on Reset_In=1, immediately and asynchronously force state to IDLE, pointer to 3 (port 0 first), Result_Valid_Out 0, Result_Data_Out 0, Result_Id_Out 0, Req_Ready_Out 0, Busy_Out 0.
REQ-025 SHALL drop any in-flight operation or pending result when reset is asserted mid-operation; no result is produced for it after reset releases.

Structure
REQ-026 SHALL place the FSM state encoding, NUM_PORTS and operand/result width constants in a shared package.
REQ-027 SHALL instantiate exactly one sub-module, Unsigned_Array_Multiplier_4_Bit, fed from the operand registers.

Verification
REQ-028 SHALL cover single request: port 2 requests A=15, B=15 -> Req_Ready_Out=4'b0100 for one cycle; 2 cycles later Result_Data_Out=225, Result_Id_Out=2.
REQ-029 SHALL cover all-ports contention after reset: all four ports held valid with Result_Ready_In=1 -> grants in order 0,1,2,3,0, one grant every 2 cycles.
REQ-030 SHALL cover backpressure: Result_Ready_In=0 for 5 cycles with port 1 valid (A=7, B=9) -> Result_Data_Out stays 63 and Result_Valid_Out stays high, Req_Ready_Out=0; on release port 1 is granted in the same cycle.
REQ-031 SHALL cover zero operand: A=0, B=13 -> Result_Data_Out=0, Result_Valid_Out=1.
REQ-032 SHALL cover reset during MULT: Reset_In pulsed while in MULT -> outputs return to reset values immediately, with no Result_Valid_Out afterwards until a new request arrives.
REQ-033 SHALL cover withdrawn request: port 3 valid for one cycle while the block is in MULT, then deasserted -> port 3 is never granted and there is no result with id 3.
